// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK phase sequencer and the sine table it drives.
//   DATA_WIDTH       phase index width (shared with wave_table_sine)
//   SINE_RESOLUTION  samples per half carrier period
//   PHASE_PERIOD     samples per full carrier period
package bpsk_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int SINE_RESOLUTION = 8;
  localparam int PHASE_PERIOD    = 2 * SINE_RESOLUTION;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } bpsk_seq_state_t;

  // Carrier step plus an optional half-period offset, folded back into one
  // period with a single conditional subtract.
  function automatic logic [DATA_WIDTH-1:0] phase_of(input logic [DATA_WIDTH-1:0] step,
                                                     input logic                  offset);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, step} + (offset ? (DATA_WIDTH+1)'(SINE_RESOLUTION) : '0);
    if (sum >= (DATA_WIDTH+1)'(PHASE_PERIOD))
      sum = sum - (DATA_WIDTH+1)'(PHASE_PERIOD);
    return sum[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/bpsk_carrier_counter.sv
// Carrier timing chain: clock divider -> phase step -> carrier period count.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_run            advance the chain this cycle (held at zero otherwise)
//   o_step_nxt       step value the chain will hold after this edge
//   o_sym_end        current cycle is the last clock of a symbol
//   o_sym_end_nxt    next cycle will be the last clock of a symbol
module bpsk_carrier_counter
  import bpsk_pkg::*;
#(
  parameter int DIVIDER         = 4,
  parameter int PERIODS_PER_BIT = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  output logic [DATA_WIDTH-1:0] o_step_nxt,
  output logic                  o_sym_end,
  output logic                  o_sym_end_nxt
);

  localparam int DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int PER_W = (PERIODS_PER_BIT > 1) ? $clog2(PERIODS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0]      DIV_MAX  = DIV_W'(DIVIDER - 1);
  localparam logic [DATA_WIDTH-1:0] STEP_MAX = DATA_WIDTH'(PHASE_PERIOD - 1);
  localparam logic [PER_W-1:0]      PER_MAX  = PER_W'(PERIODS_PER_BIT - 1);

  logic [DIV_W-1:0]      r_div_cnt,    w_div_nxt;
  logic [DATA_WIDTH-1:0] r_step,       w_step_nxt;
  logic [PER_W-1:0]      r_period_cnt, w_period_nxt;

  // All three counters wrap together at a symbol end, so a running chain
  // rolls straight into the next symbol with no idle cycle.
  always_comb begin
    w_div_nxt    = r_div_cnt;
    w_step_nxt   = r_step;
    w_period_nxt = r_period_cnt;
    if (i_run) begin
      if (r_div_cnt == DIV_MAX) begin
        w_div_nxt = '0;
        if (r_step == STEP_MAX) begin
          w_step_nxt   = '0;
          w_period_nxt = (r_period_cnt == PER_MAX) ? '0 : r_period_cnt + PER_W'(1);
        end else begin
          w_step_nxt = r_step + DATA_WIDTH'(1);
        end
      end else begin
        w_div_nxt = r_div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt    <= '0;
      r_step       <= '0;
      r_period_cnt <= '0;
    end else begin
      r_div_cnt    <= w_div_nxt;
      r_step       <= w_step_nxt;
      r_period_cnt <= w_period_nxt;
    end
  end

  assign o_step_nxt    = w_step_nxt;
  assign o_sym_end     = (r_div_cnt == DIV_MAX) && (r_step == STEP_MAX) && (r_period_cnt == PER_MAX);
  assign o_sym_end_nxt = (w_div_nxt == DIV_MAX) && (w_step_nxt == STEP_MAX) && (w_period_nxt == PER_MAX);

endmodule

// File: rtl/bpsk_phase_sequencer.sv
// BPSK phase sequencer: accepts serial bits over valid/ready, sends an
// unmodulated preamble, then steps the sine-table phase index, adding a
// half-period offset for every 1 bit.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_bit_valid/data/last, o_bit_ready   bit source handshake
//   o_phase            sine table index (registered)
//   o_active           carrier being transmitted (registered)
//   o_symbol_strobe    last clock of every symbol (registered)
//   o_underrun         frame aborted for lack of data (registered pulse)
//
// state    | meaning
// IDLE     | no carrier, phase 0, counters 0, ready for first bit
// PREAMBLE | carrier with zero offset, first bit held in cur_bit
// DATA     | carrier with offset of cur_bit
module bpsk_phase_sequencer
  import bpsk_pkg::*;
#(
  parameter int DIVIDER          = 4,
  parameter int PERIODS_PER_BIT  = 2,
  parameter int PREAMBLE_SYMBOLS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_bit_valid,
  input  logic                  i_bit_data,
  input  logic                  i_bit_last,
  output logic                  o_bit_ready,
  output logic [DATA_WIDTH-1:0] o_phase,
  output logic                  o_active,
  output logic                  o_symbol_strobe,
  output logic                  o_underrun
);

  localparam int PRE_W = (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'((PREAMBLE_SYMBOLS > 0) ? PREAMBLE_SYMBOLS - 1 : 0);

  bpsk_seq_state_t       r_state, w_state_nxt;
  logic                  r_cur_bit, w_bit_nxt;
  logic                  r_cur_last, w_last_nxt;
  logic [PRE_W-1:0]      r_pre_cnt, w_pre_nxt;
  logic                  w_underrun_nxt;
  logic [DATA_WIDTH-1:0] r_phase;
  logic                  r_active, r_symbol_strobe, r_underrun;
  logic [DATA_WIDTH-1:0] w_step_nxt;
  logic                  w_sym_end, w_sym_end_nxt;

  bpsk_carrier_counter #(
    .DIVIDER         (DIVIDER),
    .PERIODS_PER_BIT (PERIODS_PER_BIT)
  ) u_carrier_counter (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_run         (r_state != IDLE),
    .o_step_nxt    (w_step_nxt),
    .o_sym_end     (w_sym_end),
    .o_sym_end_nxt (w_sym_end_nxt)
  );

  // Ready is a function of state and counters only, never of valid.
  assign o_bit_ready = (r_state == IDLE) ||
                       ((r_state == DATA) && w_sym_end && !r_cur_last);

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_nxt      = r_cur_bit;
    w_last_nxt     = r_cur_last;
    w_pre_nxt      = r_pre_cnt;
    w_underrun_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_bit_valid) begin
          w_bit_nxt   = i_bit_data;
          w_last_nxt  = i_bit_last;
          w_pre_nxt   = '0;
          w_state_nxt = (PREAMBLE_SYMBOLS > 0) ? PREAMBLE : DATA;
        end
      end
      PREAMBLE: begin
        if (w_sym_end) begin
          if (r_pre_cnt == PRE_LAST) begin
            w_pre_nxt   = '0;
            w_state_nxt = DATA;
          end else begin
            w_pre_nxt = r_pre_cnt + PRE_W'(1);
          end
        end
      end
      DATA: begin
        if (w_sym_end) begin
          if (r_cur_last) begin
            w_state_nxt = IDLE;
          end else if (i_bit_valid) begin
            w_bit_nxt  = i_bit_data;
            w_last_nxt = i_bit_last;
          end else begin
            w_underrun_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle values so that they line up with
  // the counters: the sample for a given step appears in the same cycle the
  // counters hold that step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_cur_bit       <= 1'b0;
      r_cur_last      <= 1'b0;
      r_pre_cnt       <= '0;
      r_phase         <= '0;
      r_active        <= 1'b0;
      r_symbol_strobe <= 1'b0;
      r_underrun      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cur_bit       <= w_bit_nxt;
      r_cur_last      <= w_last_nxt;
      r_pre_cnt       <= w_pre_nxt;
      r_active        <= (w_state_nxt != IDLE);
      r_phase         <= (w_state_nxt == IDLE) ? '0 :
                         phase_of(w_step_nxt, w_bit_nxt && (w_state_nxt == DATA));
      r_symbol_strobe <= w_sym_end_nxt && (w_state_nxt != IDLE);
      r_underrun      <= w_underrun_nxt;
    end
  end

  assign o_phase         = r_phase;
  assign o_active        = r_active;
  assign o_symbol_strobe = r_symbol_strobe;
  assign o_underrun      = r_underrun;

endmodule

// File: tb/tb_bpsk_phase_sequencer.sv
// Bench for bpsk_phase_sequencer with N=8, DIVIDER=2, PERIODS_PER_BIT=1,
// PREAMBLE_SYMBOLS=1 (32 clocks per symbol).
module tb_bpsk_phase_sequencer;
  import bpsk_pkg::*;

  localparam int DIV = 2;
  localparam int PPB = 1;
  localparam int PRE = 1;
  localparam int SYM = DIV * PHASE_PERIOD * PPB;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  bit_valid = 1'b0;
  logic                  bit_data = 1'b0;
  logic                  bit_last = 1'b0;
  logic                  bit_ready;
  logic [DATA_WIDTH-1:0] phase;
  logic                  active;
  logic                  symbol_strobe;
  logic                  underrun;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] phase;
    logic                  strobe;
  } exp_t;
  exp_t sb_q[$];

  bpsk_phase_sequencer #(
    .DIVIDER          (DIV),
    .PERIODS_PER_BIT  (PPB),
    .PREAMBLE_SYMBOLS (PRE)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_bit_valid     (bit_valid),
    .i_bit_data      (bit_data),
    .i_bit_last      (bit_last),
    .o_bit_ready     (bit_ready),
    .o_phase         (phase),
    .o_active        (active),
    .o_symbol_strobe (symbol_strobe),
    .o_underrun      (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  // Expected samples for one symbol: each phase step held DIV clocks.
  task automatic push_symbol(input logic off);
    exp_t e;
    for (int k = 0; k < SYM; k++) begin
      e.phase  = DATA_WIDTH'((((k / DIV) % PHASE_PERIOD) + (off ? SINE_RESOLUTION : 0)) % PHASE_PERIOD);
      e.strobe = (k == SYM - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bit_valid = 1'b0;
    repeat (3) step_clk();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (phase !== '0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (symbol_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", symbol_strobe); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bit_ready); end
    reset = 1'b0;
    step_clk();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL post_reset_active got=%b exp=0", active); end
  endtask

  task automatic test_reset_mid_frame;
    int und_seen;
    int act_seen;
    bit_valid = 1'b1; bit_data = 1'b1; bit_last = 1'b0;
    step_clk();
    bit_valid = 1'b0;
    repeat (40) step_clk();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL midreset_in_data active got=%b exp=1", active); end
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL midreset_active got=%b exp=0", active); end
    checks++; if (phase !== '0) begin errors++; $display("FAIL midreset_phase got=%0d exp=0", phase); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midreset_underrun got=%b exp=0", underrun); end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", bit_ready); end
    und_seen = 0; act_seen = 0;
    repeat (80) begin
      step_clk();
      if (underrun) und_seen++;
      if (active) act_seen++;
    end
    checks++; if (und_seen != 0 || act_seen != 0) begin
      errors++; $display("FAIL midreset_quiet underrun=%0d active=%0d exp=0,0", und_seen, act_seen);
    end
  endtask

  // One frame with bit_valid held high whenever a bit is pending; the
  // scoreboard checks every active sample. Entered and left in an IDLE cycle.
  task automatic test_frame(input logic [7:0] bits, input int nbits, input string name);
    int idx, hs, act, strobes, cyc, und_seen;
    bit done, pre_ready_bad;
    exp_t e;
    idx = 0; hs = 0; act = 0; strobes = 0; cyc = 0; und_seen = 0;
    done = 1'b0; pre_ready_bad = 1'b0;
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready got=%b exp=1", name, bit_ready); end
    bit_valid = 1'b1; bit_data = bits[0]; bit_last = (nbits == 1);
    for (int p = 0; p < PRE; p++) push_symbol(1'b0);
    push_symbol(bits[0]);
    idx = 1; hs = 1;
    step_clk();
    checks++; if (active !== 1'b1 || phase !== '0) begin
      errors++; $display("FAIL %s start active=%b phase=%0d exp=1,0", name, active, phase);
    end
    while (!done && cyc < SYM * (nbits + PRE) + 20) begin
      if (underrun) und_seen++;
      if (active) begin
        act++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL %s extra_sample phase=%0d at active cycle %0d", name, phase, act);
        end else begin
          e = sb_q.pop_front();
          if (phase !== e.phase || symbol_strobe !== e.strobe) begin
            errors++;
            $display("FAIL %s sample%0d phase=%0d strobe=%b exp=%0d,%b", name, act, phase, symbol_strobe, e.phase, e.strobe);
          end
        end
        if (symbol_strobe) strobes++;
        if (act <= SYM * PRE && bit_ready) pre_ready_bad = 1'b1;
      end else begin
        done = 1'b1;
      end
      if (!done) begin
        if (idx < nbits) begin
          bit_valid = 1'b1; bit_data = bits[idx]; bit_last = (idx == nbits - 1);
        end else begin
          bit_valid = 1'b0;
        end
        if (bit_valid && bit_ready) begin
          checks++; if (symbol_strobe !== 1'b1) begin
            errors++; $display("FAIL %s handshake_off_sym_end strobe=%b exp=1", name, symbol_strobe);
          end
          push_symbol(bit_data);
          idx++; hs++;
        end
        step_clk();
        cyc++;
      end
    end
    bit_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL %s timeout active still %b exp=0", name, active); end
    checks++; if (hs != nbits) begin errors++; $display("FAIL %s handshakes got=%0d exp=%0d", name, hs, nbits); end
    checks++; if (act != SYM * (PRE + nbits)) begin errors++; $display("FAIL %s active_len got=%0d exp=%0d", name, act, SYM * (PRE + nbits)); end
    checks++; if (strobes != PRE + nbits) begin errors++; $display("FAIL %s strobes got=%0d exp=%0d", name, strobes, PRE + nbits); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL %s missing_samples got=%0d exp=0", name, sb_q.size()); end
    checks++; if (pre_ready_bad) begin errors++; $display("FAIL %s ready_in_preamble got=1 exp=0", name); end
    checks++; if (und_seen != 0) begin errors++; $display("FAIL %s underrun got=%0d exp=0", name, und_seen); end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL %s end_ready got=%b exp=1", name, bit_ready); end
    sb_q.delete();
  endtask

  task automatic test_backpressure;
    int act, accept_at, cyc;
    bit ready_early;
    act = 0; accept_at = -1; cyc = 0; ready_early = 1'b0;
    bit_valid = 1'b1; bit_data = 1'b0; bit_last = 1'b0;
    step_clk();
    bit_data = 1'b1; bit_last = 1'b1;
    while (accept_at < 0 && cyc < 4 * SYM) begin
      if (active) act++;
      if (bit_ready) begin
        if (act < SYM * (PRE + 1)) ready_early = 1'b1;
        accept_at = act;
      end
      step_clk();
      cyc++;
    end
    bit_valid = 1'b0;
    checks++; if (ready_early) begin errors++; $display("FAIL bp_ready_early at active cycle %0d exp=%0d", accept_at, SYM * (PRE + 1)); end
    checks++; if (accept_at != SYM * (PRE + 1)) begin
      errors++; $display("FAIL bp_accept_cycle got=%0d exp=%0d", accept_at, SYM * (PRE + 1));
    end
    cyc = 0;
    while (active && cyc < 4 * SYM) begin step_clk(); cyc++; end
    checks++; if (active !== 1'b0 || cyc != SYM) begin
      errors++; $display("FAIL bp_frame_end active=%b tail=%0d exp=0,%0d", active, cyc, SYM);
    end
  endtask

  task automatic test_underrun;
    int act, cyc, und_early;
    exp_t e;
    act = 0; cyc = 0; und_early = 0;
    bit_valid = 1'b1; bit_data = 1'b1; bit_last = 1'b0;
    for (int p = 0; p < PRE; p++) push_symbol(1'b0);
    push_symbol(1'b1);
    step_clk();
    bit_valid = 1'b0;
    while (active && cyc < 4 * SYM) begin
      act++;
      if (underrun) und_early++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL underrun_extra_sample phase=%0d", phase);
      end else begin
        e = sb_q.pop_front();
        if (phase !== e.phase || symbol_strobe !== e.strobe) begin
          errors++; $display("FAIL underrun_sample%0d phase=%0d strobe=%b exp=%0d,%b", act, phase, symbol_strobe, e.phase, e.strobe);
        end
      end
      step_clk();
      cyc++;
    end
    checks++; if (act != SYM * (PRE + 1)) begin errors++; $display("FAIL underrun_active_len got=%0d exp=%0d", act, SYM * (PRE + 1)); end
    checks++; if (underrun !== 1'b1 || und_early != 0) begin
      errors++; $display("FAIL underrun_pulse got=%b early=%0d exp=1,0", underrun, und_early);
    end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL underrun_idle_ready got=%b exp=1", bit_ready); end
    step_clk();
    checks++; if (underrun !== 1'b0 || active !== 1'b0) begin
      errors++; $display("FAIL underrun_single underrun=%b active=%b exp=0,0", underrun, active);
    end
    sb_q.delete();
  endtask

  task automatic test_back_to_back;
    test_frame(8'b0000_0000, 1, "b2b_first");
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL b2b_gap active got=%b exp=0", active); end
    test_frame(8'b0000_0001, 1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_frame(8'b0000_0000, 1, "bit0");
    test_frame(8'b0000_0001, 1, "bit1");
    test_frame(8'b0000_0101, 3, "stream101");
    test_backpressure();
    test_underrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpsk_phase_sequencer.md
# bpsk_phase_sequencer

Drives the phase index into `wave_table_sine` to produce a BPSK carrier from a serial bit stream. Accepts data bits over a valid/ready handshake, runs an unmodulated preamble, then steps the carrier phase through the full table period. For each `1` bit it offsets the phase by half a period (180°). Sits between the bit source (framer/serializer) and the sine table; the table's `signal` output is the modulator output.

## Interface
Parameters:
- `DATA_WIDTH`, 8, phase index width; taken from `bpsk_pkg`.
- `SINE_RESOLUTION`, 8, samples per half carrier period; full period is 2·SINE_RESOLUTION; taken from `bpsk_pkg`.
- `DIVIDER`, 4, clocks per phase step, ≥1.
- `PERIODS_PER_BIT`, 2, carrier periods per symbol, ≥1.
- `PREAMBLE_SYMBOLS`, 4, unmodulated symbols sent before the first data bit, ≥0.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `bit_valid`  in  1  source has a bit.
- `bit_data`  in  1  bit value; `1` means 180° phase offset.
- `bit_last`  in  1  marks the final bit of a frame; qualified by `bit_valid`.
- `bit_ready`  out  1  sequencer accepts the bit this cycle.
- `phase`  out  DATA_WIDTH  table index, range 0..2·SINE_RESOLUTION-1.
- `active`  out  1  carrier being transmitted.
- `symbol_strobe`  out  1  one-cycle pulse on the last clock of every symbol, preamble included.
- `underrun`  out  1  one-cycle pulse when the frame aborts for lack of data.

## Operation
- States:
  - IDLE: `active`=0, `phase`=0, all counters 0.
  - PREAMBLE: carrier sent with offset 0.
  - DATA: carrier sent with the offset of the current bit.
- Counters:
  - `div_cnt` runs 0..DIVIDER-1.
  - `step` runs 0..2N-1 (N=SINE_RESOLUTION) and advances when `div_cnt`=DIVIDER-1.
  - `period_cnt` runs 0..PERIODS_PER_BIT-1 and advances when `step` wraps.
  - `pre_cnt` counts preamble symbols.
- `sym_end` = `div_cnt`=DIVIDER-1 ∧ `step`=2N-1 ∧ `period_cnt`=PERIODS_PER_BIT-1.
- `phase` = (`step` + (`cur_bit` ? N : 0)) mod 2N. Compute as a conditional subtract; no divider.
- `bit_ready` is combinational:
  - high throughout IDLE;
  - in DATA, high only in the `sym_end` cycle and only if `cur_last`=0;
  - low otherwise, including the whole of PREAMBLE.
- IDLE, handshake: capture `cur_bit`/`cur_last`. Go to PREAMBLE, or straight to DATA if PREAMBLE_SYMBOLS=0.
- PREAMBLE, `sym_end`: increment `pre_cnt`. At PREAMBLE_SYMBOLS go to DATA with the buffered bit.
- DATA, `sym_end`:
  - `cur_last`=1: go to IDLE.
  - handshake: load the new bit; counters wrap to 0 seamlessly, with no gap cycle.
  - `bit_valid`=0: pulse `underrun`, go to IDLE.
- Bit value is fixed for the whole symbol. Phase discontinuities occur only at symbol boundaries.

## Timing
- Reset values: `phase`=0, `active`=0, `symbol_strobe`=0, `underrun`=0; state IDLE; counters 0.
- `phase`, `active`, `symbol_strobe` and `underrun` are registered. `bit_ready` is combinational from state/counters and never depends on `bit_valid`.
- Start latency: handshake in IDLE at cycle t → `active`=1 and `phase`=0 at t+1.
- Symbol length: DIVIDER·2N·PERIODS_PER_BIT clocks. `symbol_strobe` is high in the output cycle of the last sample of each symbol.
- End of frame: `active` falls in the cycle after the last symbol's final sample.
- Back-to-back frames: a handshake in the IDLE cycle right after a frame end restarts with the preamble. Minimum one IDLE cycle between frames.
- Reset mid-frame: IDLE on the next cycle, no `underrun` pulse, and any pending bit is discarded.
- `bit_valid` deasserted while `bit_ready`=0 has no effect.

## Structure
- `bpsk_pkg` holds:
  - `DATA_WIDTH` and `SINE_RESOLUTION`, shared with `wave_table_sine`;
  - the state enum `bpsk_seq_state_t` (IDLE, PREAMBLE, DATA);
  - `PHASE_PERIOD` = 2·SINE_RESOLUTION.
- One natural sub-module is `bpsk_carrier_counter` (`div_cnt`/`step`/`period_cnt`, emits `sym_end`). The FSM and handshake stay in the top.
- The sine table is instantiated by the parent, not inside this block.

## Test plan
All scenarios use N=8, DIVIDER=2, PERIODS_PER_BIT=1, PREAMBLE_SYMBOLS=1 (32 clocks/symbol).
- Reset mid-frame: assert `reset` in DATA → next cycle `active`=0, `phase`=0, no `underrun`; `bit_ready`=1 in IDLE.
- Single frame, bit 0 with `bit_last`:
  - `active` rises 1 cycle after the handshake;
  - `phase` sequence 0,0,1,1,…,15,15 repeated for 2 symbols;
  - 2 `symbol_strobe` pulses;
  - `active` falls 64 cycles after it rose.
- Bit 1: `phase` in the DATA symbol is 8,8,9,9,…,15,15,0,0,…,7,7. Table output is inverted relative to the preamble.
- Stream 1,0,1 (last on third), `bit_valid` held high:
  - exactly 3 DATA handshakes, each in a `sym_end` cycle;
  - offset toggles 8→0→8 at symbol boundaries with no gap cycles;
  - total `active` = 128 cycles.
- Underrun: frame of 1 bit without `bit_last`, `bit_valid` low afterwards → `underrun` pulses once at end of the first DATA symbol; `active` falls the next cycle.
- Backpressure: `bit_valid` held high during PREAMBLE → `bit_ready`=0 throughout; the second bit is accepted only at the first DATA `sym_end`.
